// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES decryption constants: inverse S-box table, FSM state
//            encoding for the sequential inverse SubBytes stage, byte geometry.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Byte geometry of one 128-bit AES state
  localparam int STATE_BYTES = 16;
  localparam int BYTE_W      = 8;
  localparam int STATE_W     = STATE_BYTES * BYTE_W;

  // Sequencer states of the inverse SubBytes stage
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } isb_state_e;

  // FIPS-197 inverse S-box, indexed by the input byte
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage : aes_pkg
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
// Module   : inv_sbox
// Brief    : Single-byte combinational AES inverse S-box lookup.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Direct table lookup; synthesis maps the constant array to logic
  assign out_byte = INV_SBOX[in_byte];

endmodule : inv_sbox
`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_seq
// Brief    : Sequential AES inverse SubBytes. Accepts one 128-bit state,
//            substitutes LANES bytes per cycle through a small bank of shared
//            inverse S-boxes, then holds the result under valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int STEPS = STATE_BYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  // Only divisors of 16 that are powers of two give an even byte walk
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  isb_state_e         state;
  isb_state_e         state_nxt;
  logic [STATE_W-1:0] work;
  logic [STATE_W-1:0] work_sub;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               sub_en;
  logic               cnt_last;

  logic [3:0] byte_idx [LANES];
  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  assign cnt_last = (cnt == CNT_LAST);

  // One shared S-box per lane; lane i serves byte cnt*LANES+i this step
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign byte_idx[i] = 4'(int'(cnt) * LANES + i);
    assign lane_in[i]  = work[{byte_idx[i], 3'b000} +: 8];

    inv_sbox u_inv_sbox (
      .in_byte  (lane_in[i]),
      .out_byte (lane_out[i])
    );
  end

  // Write the substituted lane bytes back over the current slice of work
  always_comb begin
    work_sub = work;
    for (int i = 0; i < LANES; i++) begin
      work_sub[{byte_idx[i], 3'b000} +: 8] = lane_out[i];
    end
  end

  // Next-state and handshake decode; in_ready never looks at in_valid
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    sub_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        sub_en = 1'b1;
        if (cnt_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Working state and step counter; a new load always wins over stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
    end else if (load) begin
      work <= state_in;
      cnt  <= '0;
    end else if (sub_en) begin
      work <= work_sub;
      cnt  <= cnt + 1'b1;
    end
  end

  assign state_out = work;
  assign busy      = (state != ST_IDLE);

endmodule : inv_sub_bytes_seq
`default_nettype wire
